// File: rtl/line_buf_reader.sv
// Line-buffer FIFO read controller: one gap-free H_ACTIVE pixel line per request.
// Define LINE_BUF_RD_STAT_EN to build the saturating padded-pixel counter.
module line_buf_reader #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    H_ACTIVE   = 1024,
    parameter int                    CNT_WIDTH  = 11,
    parameter int                    RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] PAD_VAL    = '0
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  line_req,
    input  logic                  fifo_rd_empty,
    input  logic                  fifo_almost_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_valid,
    output logic                  pix_last,
    output logic                  line_busy,
    output logic                  line_done,
    output logic                  underrun,
    output logic                  req_drop,
    input  logic                  clr_stat,
    output logic [15:0]           underrun_cnt
);

    typedef enum logic [1:0] {IDLE, PRIME, READ, DRAIN} state_e;

    localparam logic [CNT_WIDTH-1:0] LAST_SLOT = CNT_WIDTH'(H_ACTIVE - 1);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   slot_v, slot_last;

    // Per-stage flags {valid, hit, last}, aligned with FIFO read latency
    logic [2:0]             pipe_q [RD_LATENCY];
    logic                   v_out, hit_out, last_out, pad_out;

    logic [DATA_WIDTH-1:0]  pix_data_q;
    logic                   pix_valid_q, pix_last_q;
    logic                   line_done_q, underrun_q, req_drop_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fifo_rd_en = 1'b0;
        slot_v     = 1'b0;
        slot_last  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (line_req) state_d = PRIME;
            end
            PRIME: begin
                if (!fifo_almost_empty) state_d = READ;
            end
            READ: begin
                slot_v     = 1'b1;
                fifo_rd_en = !fifo_rd_empty;
                slot_last  = (cnt_q == LAST_SLOT);
                if (slot_last) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                // Leave once the final slot is on the output flops
                if (pix_last_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign v_out    = pipe_q[RD_LATENCY-1][2];
    assign hit_out  = pipe_q[RD_LATENCY-1][1];
    assign last_out = pipe_q[RD_LATENCY-1][0];
    assign pad_out  = v_out & ~hit_out;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            line_done_q <= 1'b0;
            underrun_q  <= 1'b0;
            req_drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = RD_LATENCY - 1; i > 0; i--) pipe_q[i] <= pipe_q[i-1];
            pipe_q[0]   <= {slot_v, fifo_rd_en, slot_last};
            pix_valid_q <= v_out;
            pix_last_q  <= v_out & last_out;
            if (v_out) pix_data_q <= hit_out ? fifo_rd_data : PAD_VAL;
            line_done_q <= pix_last_q;
            req_drop_q  <= line_req && (state_q != IDLE);
            if (clr_stat)     underrun_q <= 1'b0;
            else if (pad_out) underrun_q <= 1'b1;
        end
    end

`ifdef LINE_BUF_RD_STAT_EN
    logic [15:0] ucnt_q;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            ucnt_q <= '0;
        end else if (clr_stat) begin
            ucnt_q <= '0;
        end else if (pad_out && (ucnt_q != 16'hFFFF)) begin
            ucnt_q <= ucnt_q + 16'd1;
        end
    end

    assign underrun_cnt = ucnt_q;
`else
    assign underrun_cnt = '0;
`endif

    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign pix_last  = pix_last_q;
    assign line_busy = (state_q != IDLE);
    assign line_done = line_done_q;
    assign underrun  = underrun_q;
    assign req_drop  = req_drop_q;

endmodule

// File: doc/line_buf_reader.md
Name: line_buf_reader

Overview:
- Read-side controller for the pixel line-buffer FIFO.
- On a per-line request from the display timing generator, it pops exactly H_ACTIVE words from the FIFO read port.
- It emits them as a continuous, gap-free pixel stream with valid and last markers.
- FIFO underrun never stalls the stream: missing pixels are replaced with PAD_VAL and flagged.

Parameters:
- DATA_WIDTH, 8, pixel/FIFO word width.
- H_ACTIVE, 1024, pixels per line (legal 2..2^CNT_WIDTH-1).
- CNT_WIDTH, 11, width of the slot counter.
- RD_LATENCY, 1, FIFO rd_en-to-rd_data latency in cycles (legal 1 or 2; 2 when FIFO output register is enabled).
- PAD_VAL, 0, value substituted for pixels lost to underrun.

Ports:
- rd_clk  in  1  read-domain clock; all logic posedge.
- rd_rst_n  in  1  asynchronous active-low reset, synchronous release by integration.
- line_req  in  1  one-cycle pulse, request one line.
- fifo_rd_empty  in  1  FIFO empty flag.
- fifo_almost_empty  in  1  FIFO almost-empty flag.
- fifo_rd_data  in  DATA_WIDTH  FIFO read data.
- fifo_rd_en  out  1  FIFO pop strobe.
- pix_data  out  DATA_WIDTH  output pixel.
- pix_valid  out  1  pixel slot valid.
- pix_last  out  1  last slot of line, coincident with pix_valid.
- line_busy  out  1  high from request acceptance through final slot output.
- line_done  out  1  one-cycle pulse, cycle after pix_last.
- underrun  out  1  sticky: at least one padded pixel since reset/clr_stat.
- req_drop  out  1  one-cycle pulse: line_req arrived while not IDLE.
- clr_stat  in  1  synchronous clear of underrun and underrun_cnt.
- underrun_cnt  out  16  padded-pixel count, saturating (see Optional Feature).

Behaviour:
- Reset (rd_rst_n=0, asynchronous): FSM to IDLE, slot counter 0, delay pipes cleared.
  - All outputs 0 (pix_data=0, underrun=0, underrun_cnt=0).
- FSM states: IDLE, PRIME, READ, DRAIN.
- IDLE: line_req=1 moves to PRIME; line_busy asserts in the next cycle.
- PRIME: wait until fifo_almost_empty=0, then go to READ. Waiting is unbounded and no reads occur.
- READ: one slot per cycle, H_ACTIVE slots, slot counter 0..H_ACTIVE-1.
  - Per slot: fifo_rd_en = ~fifo_rd_empty (combinational with state). The slot is a "hit" if rd_en=1, a "pad" otherwise.
  - After slot H_ACTIVE-1, go to DRAIN. fifo_rd_en is never asserted outside READ.
- DRAIN: hold RD_LATENCY cycles until the last slot exits the pipe, then go to IDLE.
  - line_busy deasserts together with the line_done pulse.
- Output pipeline:
  - Slot-valid, hit, and last flags each delayed RD_LATENCY cycles.
  - pix_valid = delayed slot-valid.
  - pix_data = delayed hit ? fifo_rd_data : PAD_VAL, registered so that pix_* are flop outputs.
  - Total latency from a slot's rd_en cycle to its pix_valid is RD_LATENCY+1.
  - pix_data holds its last value when pix_valid=0.
- pix_valid is continuous for exactly H_ACTIVE cycles per line, with no gaps, regardless of underrun.
- Underrun: each pad slot sets underrun when it reaches the output (same cycle as its pix_valid).
- req_drop: line_req while in PRIME/READ/DRAIN is ignored and pulses req_drop the next cycle; the line in progress is unaffected.
- clr_stat has priority over a same-cycle underrun set: the result is cleared, and that pad is not counted.
- Empty at READ entry is legal: the slot pads.
- A FIFO that refills mid-line resumes hits on the first slot where fifo_rd_empty=0.

Optional Feature:
- Macro: LINE_BUF_RD_STAT_EN.
- Defined: underrun_cnt increments by 1 per padded pixel at output, saturates at 16'hFFFF, and is cleared by reset or clr_stat.
- Undefined: the counter logic is omitted; underrun_cnt is tied to 0. The underrun flag and clr_stat on underrun remain functional.

Test Plan:
- H_ACTIVE=16, RD_LATENCY=1, FIFO preloaded with 0x00..0x1F, one line_req:
  - PRIME exits at once; 16 consecutive pix_valid with data 0x00..0x0F.
  - pix_last on 0x0F; line_done next cycle; underrun=0; 16 words remain in FIFO.
- FIFO holds 4 words, almost_empty threshold 4:
  - FSM stays in PRIME with fifo_rd_en=0 until a 5th word is written.
  - First pix_valid appears RD_LATENCY+2 cycles after almost_empty falls.
- H_ACTIVE=16, FIFO has 10 words with no refill, PAD_VAL=0xAA:
  - 10 data pixels then 6×0xAA, still contiguous; underrun=1.
  - underrun_cnt=6 with LINE_BUF_RD_STAT_EN, 0 without.
- RD_LATENCY=2: same stimulus as the first scenario gives identical pix output shifted one cycle later.
- line_req pulsed mid-READ: req_drop pulses once and the current line completes normally. A line_req after line_done starts a new line.
- Deassert rd_rst_n mid-READ:
  - All outputs 0 immediately; FSM in IDLE after release.
  - The next line_req produces a full H_ACTIVE-pixel line.
  - clr_stat asserted in the same cycle as a pad at output leaves underrun=0.
